// File: rtl/uart_tx_frame_buffer_pkg.sv
// Shared typedefs for the UART transmit path: frame-buffer control states and counter widths.
package uart_tx_frame_buffer_pkg;

  localparam int unsigned FRAMES_SENT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_fb_state_e;

endpackage : uart_tx_frame_buffer_pkg

// File: rtl/uart_tx_frame_buffer.sv
// Collects upstream elements into a frame register array and hands complete (or
// idle-flushed) frames to a multibyte UART sender, one frame in flight at a time.
module uart_tx_frame_buffer
  import uart_tx_frame_buffer_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH      = 8,
  parameter int unsigned NUMBER_OF_ELEMENTS = 256,
  parameter int unsigned DELAY_WIDTH        = 32,
  localparam int unsigned TRANSFER_COUNTER_WIDTH = $clog2(NUMBER_OF_ELEMENTS)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_valid,
  input  logic [ELEMENT_WIDTH-1:0]                           in_data,
  input  logic                                               in_last,
  output logic                                               in_ready,
  input  logic [DELAY_WIDTH-1:0]                             flush_timeout,
  output logic                                               tx_en,
  output logic [NUMBER_OF_ELEMENTS-1:0][ELEMENT_WIDTH-1:0]   tx_data,
  output logic [TRANSFER_COUNTER_WIDTH:0]                    tx_data_length,
  input  logic                                               tx_ready,
  output logic [FRAMES_SENT_WIDTH-1:0]                       frames_sent
);

  localparam int unsigned CNT_W = TRANSFER_COUNTER_WIDTH + 1;

  tx_fb_state_e                                       state_q, state_d;
  logic [CNT_W-1:0]                                   fill_q, fill_d;
  logic [DELAY_WIDTH-1:0]                             idle_q, idle_d;
  logic                                               tx_en_q, tx_en_d;
  logic [CNT_W-1:0]                                   len_q, len_d;
  logic [FRAMES_SENT_WIDTH-1:0]                       frames_q, frames_d;
  logic                                               in_ready_q, in_ready_d;
  logic [NUMBER_OF_ELEMENTS-1:0][ELEMENT_WIDTH-1:0]   mem_q;
  logic                                               accept_c;
  logic                                               wr_en_c;

  assign accept_c = in_valid && in_ready_q && (state_q == ST_FILL);

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    idle_d     = idle_q;
    tx_en_d    = 1'b0;
    len_d      = len_q;
    frames_d   = frames_q;
    wr_en_c    = 1'b0;
    in_ready_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          wr_en_c = 1'b1;
          fill_d  = fill_q + CNT_W'(1);
          idle_d  = '0;
          if (in_last || (fill_q == CNT_W'(NUMBER_OF_ELEMENTS - 1))) begin
            state_d = ST_LAUNCH;
          end
        end else if ((fill_q != '0) && (flush_timeout != '0)) begin
          // Timer only runs while a partial frame is pending and flushing is enabled.
          idle_d = idle_q + DELAY_WIDTH'(1);
          if (idle_d >= flush_timeout) begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        if (tx_ready) begin
          tx_en_d = 1'b1;
          len_d   = fill_q;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          frames_d = frames_q + FRAMES_SENT_WIDTH'(1);
          fill_d   = '0;
          idle_d   = '0;
          state_d  = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    in_ready_d = (state_d == ST_FILL);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      fill_q     <= '0;
      idle_q     <= '0;
      tx_en_q    <= 1'b0;
      len_q      <= '0;
      frames_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      idle_q     <= idle_d;
      tx_en_q    <= tx_en_d;
      len_q      <= len_d;
      frames_q   <= frames_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Frame storage has no reset; entries past the frame length keep stale data.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[fill_q[TRANSFER_COUNTER_WIDTH-1:0]] <= in_data;
    end
  end

  assign in_ready       = in_ready_q;
  assign tx_en          = tx_en_q;
  assign tx_data        = mem_q;
  assign tx_data_length = len_q;
  assign frames_sent    = frames_q;

endmodule : uart_tx_frame_buffer

// File: tb/tb_uart_tx_frame_buffer.sv
// Directed + randomized bench for uart_tx_frame_buffer against a queue-based frame model.
module tb_uart_tx_frame_buffer;

  localparam int unsigned EW = 8;
  localparam int unsigned NE = 256;
  localparam int unsigned DW = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [EW-1:0]      in_data;
  logic               in_last;
  logic               in_ready;
  logic [DW-1:0]      flush_timeout;
  logic               tx_en;
  logic [NE-1:0][EW-1:0] tx_data;
  logic [8:0]         tx_data_length;
  logic               tx_ready;
  logic [15:0]        frames_sent;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: elements of the frame being built, and frames completed so far.
  logic [EW-1:0] mdl_q[$];
  int unsigned   mdl_frames = 0;

  uart_tx_frame_buffer #(
    .ELEMENT_WIDTH(EW), .NUMBER_OF_ELEMENTS(NE), .DELAY_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .flush_timeout(flush_timeout),
    .tx_en(tx_en), .tx_data(tx_data), .tx_data_length(tx_data_length),
    .tx_ready(tx_ready), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_elem(input logic [EW-1:0] d, input logic last);
    chk("in_ready_fill", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mdl_q.push_back(d);
  endtask

  task automatic send_frame(input int n, input logic close);
    for (int i = 0; i < n; i++) begin
      send_elem(EW'($urandom), close && (i == n - 1));
    end
    if (close) chk("in_ready_after_close", 32'(in_ready), 32'd0);
  endtask

  // Waits for tx_en; lo returns how many sampled cycles had tx_en low first.
  task automatic wait_tx_en(input int budget, output int lo);
    lo = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (tx_en === 1'b1) break;
      lo++;
    end
    chk("tx_en_seen", 32'(tx_en), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_len"}, 32'(tx_data_length), 32'(mdl_q.size()));
    for (int i = 0; i < mdl_q.size(); i++) begin
      chk({tag, "_data"}, 32'(tx_data[i]), 32'(mdl_q[i]));
    end
  endtask

  // Sender model: called on the cycle tx_en is high; stays busy for 'busy' cycles.
  task automatic serve(input int busy);
    int bad;
    check_frame("launch");
    tx_ready = 1'b0;
    tick();
    chk("tx_en_single_pulse", 32'(tx_en), 32'd0);
    bad = 0;
    for (int k = 1; k < busy; k++) begin
      tick();
      if ((in_ready !== 1'b0) || (tx_en !== 1'b0) || (frames_sent !== 16'(mdl_frames))) bad++;
    end
    chk("busy_hold", 32'(bad), 32'd0);
    check_frame("stable");
    tx_ready = 1'b1;
    tick();
    mdl_frames++;
    chk("frames_sent", 32'(frames_sent), 32'(16'(mdl_frames)));
    chk("in_ready_after_done", 32'(in_ready), 32'd1);
    mdl_q.delete();
  endtask

  initial begin
    int lo;
    int hits;
    int n;
    int unsigned to;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    flush_timeout = '0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_len", 32'(tx_data_length), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Three-element frame closed by last.
    send_elem(8'hA1, 1'b0);
    send_elem(8'hB2, 1'b0);
    send_elem(8'hC3, 1'b1);
    chk("abc_in_ready_launch", 32'(in_ready), 32'd0);
    wait_tx_en(20, lo);
    chk("abc_latency", 32'(lo), 32'd0);
    chk("abc_d0", 32'(tx_data[0]), 32'h A1);
    chk("abc_d2", 32'(tx_data[2]), 32'h C3);
    serve(4);

    // Full buffer without last.
    send_frame(NE, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    wait_tx_en(20, lo);
    chk("full_latency", 32'(lo), 32'd0);
    chk("full_len", 32'(tx_data_length), 32'd256);
    serve(30);

    // Idle flush after 10 cycles, then flush disabled.
    flush_timeout = 32'd10;
    send_frame(2, 1'b0);
    wait_tx_en(60, lo);
    chk("flush_idle_cycles", 32'(lo), 32'd10);
    serve(5);
    flush_timeout = 32'd0;
    send_frame(2, 1'b0);
    hits = 0;
    repeat (200) begin
      tick();
      if (tx_en !== 1'b0) hits++;
    end
    chk("no_flush_when_disabled", 32'(hits), 32'd0);
    send_elem(EW'($urandom), 1'b1);
    wait_tx_en(20, lo);
    chk("closed_after_no_flush_len", 32'(tx_data_length), 32'd3);
    serve(3);

    // Sender not ready when frame closes; long busy period.
    tx_ready = 1'b0;
    send_frame(3, 1'b1);
    hits = 0;
    repeat (50) begin
      tick();
      if ((tx_en !== 1'b0) || (in_ready !== 1'b0)) hits++;
    end
    chk("launch_held_off", 32'(hits), 32'd0);
    tx_ready = 1'b1;
    wait_tx_en(20, lo);
    chk("launch_after_ready", 32'(lo), 32'd0);
    serve(1000);

    // Reset while waiting for the sender to finish.
    send_frame(3, 1'b1);
    wait_tx_en(20, lo);
    tx_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("wd_rst_tx_en", 32'(tx_en), 32'd0);
    chk("wd_rst_len", 32'(tx_data_length), 32'd0);
    chk("wd_rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    mdl_q.delete();
    mdl_frames = 0;
    hits = 0;
    repeat (5) begin
      tick();
      if (tx_en !== 1'b0) hits++;
    end
    chk("wd_rst_no_pulse", 32'(hits), 32'd0);
    chk("wd_rst_in_ready", 32'(in_ready), 32'd1);
    send_elem(8'h5C, 1'b0);
    send_elem(8'h3D, 1'b1);
    wait_tx_en(20, lo);
    chk("wd_rst_index0", 32'(tx_data[0]), 32'h5C);
    serve(2);

    // Back-to-back frames of length 1 and 4.
    send_frame(1, 1'b1);
    wait_tx_en(20, lo);
    serve(1);
    send_frame(4, 1'b1);
    wait_tx_en(20, lo);
    serve(2);
    chk("b2b_frames", 32'(frames_sent), 32'd3);

    // Randomized frames mixing last-closure and idle flush.
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1, 12));
      if (f % 2 == 1) begin
        to = $urandom_range(2, 15);
        flush_timeout = to;
        send_frame(n, 1'b0);
        wait_tx_en(60, lo);
        chk("rand_flush_idle", 32'(lo), 32'(to));
      end else begin
        flush_timeout = 32'($urandom_range(0, 1) * 40);
        send_frame(n, 1'b1);
        wait_tx_en(20, lo);
        chk("rand_last_latency", 32'(lo), 32'd0);
      end
      serve(int'($urandom_range(1, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_frame_buffer

// File: doc/uart_tx_frame_buffer.md
UART_TX_FRAME_BUFFER -- requirements
Module: uart_tx_frame_buffer

Interface
REQ-001 Parameter ELEMENT_WIDTH, default 8, bit width of one buffered element.
REQ-002 Parameter NUMBER_OF_ELEMENTS, default 256, buffer depth; localparam TRANSFER_COUNTER_WIDTH = $clog2(NUMBER_OF_ELEMENTS).
REQ-003 Parameter DELAY_WIDTH, default 32, width of flush_timeout and the idle timer.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset:
  clk  input  1  system clock, all logic on posedge
  rst  input  1  synchronous active-high reset
  in_valid  input  1  upstream element valid
  in_data  input  ELEMENT_WIDTH  upstream element
  in_last  input  1  element closes current frame
  in_ready  output  1  element accepted when in_valid && in_ready
  flush_timeout  input  DELAY_WIDTH  idle cycles before partial-frame flush; 0 disables
  tx_en  output  1  one-cycle launch pulse to multibyte sender
  tx_data  output  [NUMBER_OF_ELEMENTS-1:0][ELEMENT_WIDTH-1:0]  frame contents, element 0 sent first
  tx_data_length  output  TRANSFER_COUNTER_WIDTH+1  element count of launched frame
  tx_ready  input  1  sender idle; low from cycle after tx_en until last element sent
  frames_sent  output  16  count of completed frames, wraps

Function
REQ-005 States SHALL be FILL, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-006 FILL: in_ready = 1; each accepted element SHALL be written to tx_data[fill_count], fill_count incremented.
REQ-007 FILL -> LAUNCH on the accept cycle when in_last = 1, or fill_count reaches NUMBER_OF_ELEMENTS, whichever first.
REQ-008 FILL -> LAUNCH when fill_count > 0, flush_timeout != 0, and idle timer (cycles without accept, reset on every accept) reaches flush_timeout.
REQ-009 in_last on an element into an empty buffer SHALL produce a 1-element frame; FILL with fill_count = 0 SHALL never launch.
REQ-010 LAUNCH: in_ready = 0; when tx_ready = 1, drive tx_en = 1 for exactly one cycle, tx_data_length = fill_count, go to WAIT_BUSY.
REQ-011 WAIT_BUSY: wait for tx_ready = 0, then WAIT_DONE; WAIT_DONE: on tx_ready = 1, increment frames_sent, clear fill_count and idle timer, go to FILL.
REQ-012 tx_data and tx_data_length SHALL remain stable from tx_en until WAIT_DONE exits.
REQ-013 in_ready SHALL be 0 in LAUNCH, WAIT_BUSY, WAIT_DONE and on the cycle a full or last accept moves to LAUNCH; no element is dropped or overwritten.
REQ-014 fill_count SHALL be TRANSFER_COUNTER_WIDTH+1 bits so a full buffer (NUMBER_OF_ELEMENTS) is representable.
REQ-015 frames_sent SHALL wrap 0xFFFF -> 0x0000.
REQ-016 Unused tx_data entries beyond tx_data_length SHALL hold stale values; no clearing required.

Reset
REQ-017 On rst: state FILL, fill_count 0, idle timer 0, tx_en 0, tx_data_length 0, frames_sent 0; tx_data contents undefined.
REQ-018 rst mid-frame or mid-transmission SHALL abandon the frame without a tx_en pulse; in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-019 State enum type SHALL live in the shared hwdbg sensors package alongside other UART typedefs.
REQ-020 No sub-module; the buffer SHALL be a register array so tx_data is directly visible; fits 150-250 lines.

Verification
REQ-021 Send 3 elements 0xA1,0xB2,0xC3 with last on 0xC3, tx_ready=1 -> one tx_en pulse, tx_data_length=3, tx_data[0..2]=A1,B2,C3.
REQ-022 Stream 256 elements without last -> launch at 256th accept, tx_data_length=256, in_ready=0 until tx_ready rises again.
REQ-023 flush_timeout=10, send 2 elements then idle -> tx_en exactly 10 idle cycles after last accept, length 2; flush_timeout=0 -> no launch.
REQ-024 Hold tx_ready=0 in LAUNCH for 50 cycles -> no tx_en until tx_ready=1; model sender busy 1000 cycles -> frames_sent increments once after tx_ready returns.
REQ-025 Assert rst in WAIT_DONE -> all outputs at reset values next cycle, frames_sent=0, next frame starts at index 0.
REQ-026 Back-to-back frames of length 1 and 4 -> two tx_en pulses, frames_sent=2, second frame tx_data[0] is its first element.
